// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared encodings and types for the writeback port arbiter
package wb_port_arbiter_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arbState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [4:0]  regAddr;
        logic [31:0] data;
    } mdEntry_t;

endpackage

// File: rtl/md_result_fifo.sv
// rtl/md_result_fifo.sv - MulDiv result FIFO with per-entry invalidate-by-register
import wb_port_arbiter_pkg::*;

module md_result_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        pushEn,
    input  logic [4:0]  pushReg,
    input  logic [31:0] pushData,
    input  logic        popEn,
    input  logic        invEn,
    input  logic [4:0]  invReg,
    output logic        full,
    output logic        empty,
    output mdEntry_t    head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mdEntry_t           mem [DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic [CNT_W-1:0]   count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // The push slot is never an occupied slot, so the push below cannot undo an invalidate.
            if (invEn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].regAddr == invReg) begin
                        mem[i].valid <= 1'b0;
                    end
                end
            end
            if (pushEn) begin
                mem[wrPtr] <= '{valid: 1'b1, regAddr: pushReg, data: pushData};
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline and MulDiv
import wb_port_arbiter_pkg::*;

module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Pipe_RegWrite,
    input  logic        Pipe_Jal,
    input  logic [4:0]  Pipe_WriteReg,
    input  logic [31:0] Pipe_Data,
    input  logic [31:0] Pipe_PCPlusFour,
    input  logic        Md_Valid,
    input  logic [4:0]  Md_WriteReg,
    input  logic [31:0] Md_Data,
    output logic        Md_Ready,
    output logic        Stall_Pipe,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arbState_t          state;
    logic [WAIT_W-1:0]  waitCnt;
    logic               fifoFull;
    logic               fifoEmpty;
    mdEntry_t           fifoHead;
    logic               pipeGrant;
    logic               mdPop;
    logic               mdPush;

    always_comb begin
        pipeGrant = (state == NORMAL) && Pipe_RegWrite;
        mdPop     = !fifoEmpty && ((state == FORCE) || !Pipe_RegWrite);
    end

    assign Md_Ready   = !fifoFull || mdPop;
    assign mdPush     = Md_Valid && Md_Ready;
    assign Stall_Pipe = (state == FORCE);

    md_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .pushEn   (mdPush),
        .pushReg  (Md_WriteReg),
        .pushData (Md_Data),
        .popEn    (mdPop),
        .invEn    (pipeGrant),
        .invReg   (Pipe_WriteReg),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .head     (fifoHead)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= NORMAL;
            waitCnt   <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= REG_ZERO;
            WriteData <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (pipeGrant) begin
                RegWrite  <= (Pipe_WriteReg != REG_ZERO);
                WriteReg  <= Pipe_WriteReg;
                WriteData <= Pipe_Jal ? Pipe_PCPlusFour : Pipe_Data;
            end else if (mdPop) begin
                // Entries overwritten by a younger pipe write still drain, just silently.
                RegWrite  <= fifoHead.valid && (fifoHead.regAddr != REG_ZERO);
                WriteReg  <= fifoHead.regAddr;
                WriteData <= fifoHead.data;
            end

            case (state)
                NORMAL: begin
                    if (fifoEmpty || mdPop) begin
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
                        waitCnt <= '0;
                        state   <= FORCE;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                FORCE: begin
                    waitCnt <= '0;
                    state   <= NORMAL;
                end
                default: begin
                    waitCnt <= '0;
                    state   <= NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Pipe_RegWrite = 1'b0;
    logic        Pipe_Jal = 1'b0;
    logic [4:0]  Pipe_WriteReg = '0;
    logic [31:0] Pipe_Data = '0;
    logic [31:0] Pipe_PCPlusFour = '0;
    logic        Md_Valid = 1'b0;
    logic [4:0]  Md_WriteReg = '0;
    logic [31:0] Md_Data = '0;
    logic        Md_Ready;
    logic        Stall_Pipe;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .Pipe_RegWrite   (Pipe_RegWrite),
        .Pipe_Jal        (Pipe_Jal),
        .Pipe_WriteReg   (Pipe_WriteReg),
        .Pipe_Data       (Pipe_Data),
        .Pipe_PCPlusFour (Pipe_PCPlusFour),
        .Md_Valid        (Md_Valid),
        .Md_WriteReg     (Md_WriteReg),
        .Md_Data         (Md_Data),
        .Md_Ready        (Md_Ready),
        .Stall_Pipe      (Stall_Pipe),
        .RegWrite        (RegWrite),
        .WriteReg        (WriteReg),
        .WriteData       (WriteData)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          live;
        logic [4:0]  dest;
        logic [31:0] value;
    } pending_t;

    pending_t    pend[$];
    bit          mForcing;
    int          mDenied;
    bit          expStall, expReady, expWrite;
    logic [4:0]  expReg;
    logic [31:0] expData;
    logic        obsStall, obsReady;
    logic [31:0] rf [32];
    int          checks = 0;
    int          passes = 0;

    task automatic model_reset();
        pend.delete();
        mForcing = 0;
        mDenied  = 0;
    endtask

    // Reference: a queue of pending results plus a count of consecutive starved cycles.
    task automatic model_step(input bit pr, input bit jal, input logic [4:0] wr, input logic [31:0] pd,
                              input logic [31:0] pc, input bit mv, input logic [4:0] mr, input logic [31:0] md);
        bit hadPending;
        bit takeMd;
        pending_t e;
        hadPending = (pend.size() > 0);
        takeMd     = hadPending && (mForcing || !pr);
        expStall   = mForcing;
        expReady   = (pend.size() < DEPTH) || takeMd;
        expWrite   = 0;
        if (!mForcing && pr) begin
            expWrite = (wr != 0);
            expReg   = wr;
            expData  = jal ? pc : pd;
            foreach (pend[i]) if (pend[i].dest == wr) pend[i].live = 0;
        end else if (takeMd) begin
            e        = pend.pop_front();
            expWrite = e.live && (e.dest != 0);
            expReg   = e.dest;
            expData  = e.value;
        end
        if (mForcing) begin
            mForcing = 0;
            mDenied  = 0;
        end else if (hadPending && !takeMd) begin
            mDenied++;
            if (mDenied >= MAX_WAIT) begin
                mForcing = 1;
                mDenied  = 0;
            end
        end else begin
            mDenied = 0;
        end
        if (mv && expReady) pend.push_back('{live: 1, dest: mr, value: md});
    endtask

    task automatic cycle(input bit pr, input bit jal, input logic [4:0] wr, input logic [31:0] pd,
                         input logic [31:0] pc, input bit mv, input logic [4:0] mr, input logic [31:0] md);
        Pipe_RegWrite   = pr;
        Pipe_Jal        = jal;
        Pipe_WriteReg   = wr;
        Pipe_Data       = pd;
        Pipe_PCPlusFour = pc;
        Md_Valid        = mv;
        Md_WriteReg     = mr;
        Md_Data         = md;
        #1;
        obsStall = Stall_Pipe;
        obsReady = Md_Ready;
        model_step(pr, jal, wr, pd, pc, mv, mr, md);
        @(posedge Clk);
        @(negedge Clk);
        if (RegWrite === 1'b1) rf[WriteReg] = WriteData;
    endtask

    task automatic idle();
        cycle(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 5'd3, 32'h11, 32'd0, 1, 5'd6, 32'hA0);
        cycle(1, 0, 5'd3, 32'h12, 32'd0, 1, 5'd7, 32'hA1);
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got=%b exp=0", RegWrite); else passes++;
        checks++; if (Md_Ready !== 1'b1) $display("FAIL reset_md_ready got=%b exp=1", Md_Ready); else passes++;
        checks++; if (Stall_Pipe !== 1'b0) $display("FAIL reset_stall got=%b exp=0", Stall_Pipe); else passes++;
        checks++; if ({WriteReg, WriteData} !== 37'd0) $display("FAIL reset_wreg_wdata got=%h/%h exp=0/0", WriteReg, WriteData); else passes++;
        @(negedge Clk);
        Rst_n = 1'b1;
        idle();
        checks++; if (RegWrite !== 1'b0) $display("FAIL reset_fifo_empty got=%b exp=0", RegWrite); else passes++;
        idle();
        checks++; if (RegWrite !== 1'b0) $display("FAIL reset_fifo_empty2 got=%b exp=0", RegWrite); else passes++;
    endtask

    task automatic test_jal_link();
        cycle(1, 1, 5'd31, 32'hCAFE_0001, 32'h0040_0010, 0, 5'd0, 32'd0);
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd31, 32'h0040_0010})
            $display("FAIL jal_link got=%b/%0d/%h exp=1/31/00400010", RegWrite, WriteReg, WriteData); else passes++;
        cycle(1, 0, 5'd2, 32'h1234_5678, 32'h0040_0014, 0, 5'd0, 32'd0);
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd2, 32'h1234_5678})
            $display("FAIL pipe_data got=%b/%0d/%h exp=1/2/12345678", RegWrite, WriteReg, WriteData); else passes++;
    endtask

    task automatic test_md_push();
        cycle(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd8, 32'hDEAD_BEEF);
        checks++; if (obsReady !== 1'b1) $display("FAIL md_ready_push got=%b exp=1", obsReady); else passes++;
        checks++; if (RegWrite !== 1'b0) $display("FAIL md_no_bypass got=%b exp=0", RegWrite); else passes++;
        idle();
        checks++; if (obsReady !== 1'b1) $display("FAIL md_ready_after got=%b exp=1", obsReady); else passes++;
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd8, 32'hDEAD_BEEF})
            $display("FAIL md_write got=%b/%0d/%h exp=1/8/deadbeef", RegWrite, WriteReg, WriteData); else passes++;
    endtask

    task automatic test_force_drain();
        cycle(1, 0, 5'd3, 32'h300, 32'd0, 1, 5'd10, 32'h0000_0A0A);
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 5'd3, 32'h300 + i, 32'd0, 0, 5'd0, 32'd0);
            checks++; if (obsStall !== 1'b0) $display("FAIL force_early_stall cyc=%0d got=%b exp=0", i, obsStall); else passes++;
        end
        cycle(1, 0, 5'd3, 32'h399, 32'd0, 0, 5'd0, 32'd0);
        checks++; if (obsStall !== 1'b1) $display("FAIL force_stall got=%b exp=1", obsStall); else passes++;
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd10, 32'h0000_0A0A})
            $display("FAIL force_drain got=%b/%0d/%h exp=1/10/00000a0a", RegWrite, WriteReg, WriteData); else passes++;
        cycle(1, 0, 5'd3, 32'h3AA, 32'd0, 0, 5'd0, 32'd0);
        checks++; if (obsStall !== 1'b0) $display("FAIL force_release got=%b exp=0", obsStall); else passes++;
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd3, 32'h3AA})
            $display("FAIL force_resume got=%b/%0d/%h exp=1/3/3aa", RegWrite, WriteReg, WriteData); else passes++;
    endtask

    task automatic test_waw();
        cycle(1, 0, 5'd4, 32'h44, 32'd0, 1, 5'd9, 32'h5555_5555);
        cycle(1, 0, 5'd9, 32'h1, 32'd0, 0, 5'd0, 32'd0);
        idle();
        checks++; if (RegWrite !== 1'b0) $display("FAIL waw_stale_pop got=%b exp=0", RegWrite); else passes++;
        idle();
        checks++; if (rf[9] !== 32'h1) $display("FAIL waw_final got=%h exp=00000001", rf[9]); else passes++;
    endtask

    task automatic test_full_pushpop();
        cycle(1, 0, 5'd5, 32'h50, 32'd0, 1, 5'd11, 32'hB011);
        cycle(1, 0, 5'd5, 32'h51, 32'd0, 1, 5'd12, 32'hB012);
        cycle(1, 0, 5'd5, 32'h52, 32'd0, 0, 5'd0, 32'd0);
        checks++; if (obsReady !== 1'b0) $display("FAIL full_not_ready got=%b exp=0", obsReady); else passes++;
        cycle(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd13, 32'hB013);
        checks++; if (obsReady !== 1'b1) $display("FAIL full_pushpop_ready got=%b exp=1", obsReady); else passes++;
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd11, 32'hB011})
            $display("FAIL full_pop0 got=%b/%0d/%h exp=1/11/b011", RegWrite, WriteReg, WriteData); else passes++;
        idle();
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd12, 32'hB012})
            $display("FAIL full_pop1 got=%b/%0d/%h exp=1/12/b012", RegWrite, WriteReg, WriteData); else passes++;
        idle();
        checks++; if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd13, 32'hB013})
            $display("FAIL full_pop2 got=%b/%0d/%h exp=1/13/b013", RegWrite, WriteReg, WriteData); else passes++;
        idle();
        checks++; if (RegWrite !== 1'b0) $display("FAIL full_drained got=%b exp=0", RegWrite); else passes++;
    endtask

    task automatic test_reg_zero();
        cycle(1, 0, 5'd0, 32'h1234, 32'd0, 0, 5'd0, 32'd0);
        checks++; if (RegWrite !== 1'b0) $display("FAIL reg_zero_pipe got=%b exp=0", RegWrite); else passes++;
        cycle(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd0, 32'h77);
        idle();
        checks++; if (RegWrite !== 1'b0) $display("FAIL reg_zero_md got=%b exp=0", RegWrite); else passes++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) < 6), $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom, ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom);
            checks++;
            if ({obsStall, obsReady, RegWrite} !== {expStall, expReady, expWrite}) begin
                errs++;
                if (errs < 10) $display("FAIL rand_ctrl n=%0d got stall/ready/we=%b%b%b exp=%b%b%b",
                                        n, obsStall, obsReady, RegWrite, expStall, expReady, expWrite);
            end else passes++;
            if (expWrite) begin
                checks++;
                if ({WriteReg, WriteData} !== {expReg, expData}) begin
                    errs++;
                    if (errs < 10) $display("FAIL rand_data n=%0d got=%0d/%h exp=%0d/%h",
                                            n, WriteReg, WriteData, expReg, expData);
                end else passes++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        model_reset();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        test_reset();
        test_jal_link();
        test_md_push();
        test_force_drain();
        test_waw();
        test_full_pushpop();
        test_reg_zero();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
